// File: rtl/inv_mix_columns_iter_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helper for the iterative InvMixColumns block.
package inv_mix_columns_iter_pkg;

  localparam int unsigned NB_BYTE = 8;
  localparam int unsigned COL_W   = 32;
  localparam logic [NB_BYTE-1:0] RED_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8): shift left and fold the carry back with 0x1b.
  function automatic logic [NB_BYTE-1:0] xtime(input logic [NB_BYTE-1:0] b);
    return {b[NB_BYTE-2:0], 1'b0} ^ (b[NB_BYTE-1] ? RED_POLY : {NB_BYTE{1'b0}});
  endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns of one 32-bit column, byte a0 in the MSBs.
module inv_mix_column_word
  import inv_mix_columns_iter_pkg::*;
(
  input  logic [COL_W-1:0] i_word,
  output logic [COL_W-1:0] o_word
);

  logic [NB_BYTE-1:0] a  [4];
  logic [NB_BYTE-1:0] x2 [4];
  logic [NB_BYTE-1:0] x4 [4];
  logic [NB_BYTE-1:0] x8 [4];
  logic [NB_BYTE-1:0] m9 [4];
  logic [NB_BYTE-1:0] mb [4];
  logic [NB_BYTE-1:0] md [4];
  logic [NB_BYTE-1:0] me [4];

  // Per-byte xtime chain and the four constant multiples built from it.
  for (genvar r = 0; r < 4; r++) begin : g_byte
    assign a[r]  = i_word[COL_W-1-NB_BYTE*r -: NB_BYTE];
    assign x2[r] = xtime(a[r]);
    assign x4[r] = xtime(x2[r]);
    assign x8[r] = xtime(x4[r]);
    assign m9[r] = x8[r] ^ a[r];
    assign mb[r] = x8[r] ^ x2[r] ^ a[r];
    assign md[r] = x8[r] ^ x4[r] ^ a[r];
    assign me[r] = x8[r] ^ x4[r] ^ x2[r];
  end

  // Output row r combines the rotated multiples 0e,0b,0d,09.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign o_word[COL_W-1-NB_BYTE*r -: NB_BYTE] =
      me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one column per cycle through a shared column datapath.
module inv_mix_columns_iter
  import inv_mix_columns_iter_pkg::*;
#(
  parameter int unsigned NB_BYTE = inv_mix_columns_iter_pkg::NB_BYTE,
  parameter int unsigned N_ROWS  = 4,
  parameter int unsigned N_COLS  = 4
)
(
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_valid,
  input  logic [NB_BYTE*N_ROWS*N_COLS-1:0]  i_data,
  output logic                              o_ready,
  output logic [NB_BYTE*N_ROWS*N_COLS-1:0]  o_data,
  output logic                              o_valid,
  input  logic                              i_ready
);

  localparam int unsigned NB_DATA = NB_BYTE * N_ROWS * N_COLS;
  localparam int unsigned WCOL    = NB_BYTE * N_ROWS;
  localparam int unsigned SEL_W   = $clog2(NB_DATA);
  localparam logic [1:0]  LAST_COL = 2'(N_COLS - 1);

  // The column datapath is hard-wired for 8-bit bytes and 4-byte columns.
  if (NB_BYTE != 8 || N_ROWS != 4 || N_COLS < 1 || N_COLS > 4) begin : g_bad_cfg
    $error("inv_mix_columns_iter: bad configuration, need NB_BYTE=8, N_ROWS=4, 1<=N_COLS<=4");
  end

  state_t               state;
  logic [1:0]           col_cnt;
  logic [NB_DATA-1:0]   work;
  logic [SEL_W-1:0]     col_lsb;
  logic [WCOL-1:0]      col_in;
  logic [WCOL-1:0]      col_out;

  // Column 0 lives in the MSBs, so column c starts (N_COLS-1-c) columns up from bit 0.
  assign col_lsb = SEL_W'((N_COLS - 1 - 32'(col_cnt)) * WCOL);
  assign col_in  = work[col_lsb +: WCOL];

  // Upstream may load in IDLE, or in DONE when the result is being taken this cycle.
  assign o_ready = (state == ST_IDLE) || ((state == ST_DONE) && i_ready);
  assign o_data  = work;

  inv_mix_column_word u_col (
    .i_word (col_in),
    .o_word (col_out)
  );

  // Control FSM, column counter and in-place working register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      col_cnt <= 2'd0;
      work    <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            work    <= i_data;
            col_cnt <= 2'd0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          work[col_lsb +: WCOL] <= col_out;
          col_cnt               <= col_cnt + 2'd1;
          if (col_cnt == LAST_COL) begin
            state   <= ST_DONE;
            o_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (i_valid) begin
              work    <= i_data;
              col_cnt <= 2'd0;
              state   <= ST_BUSY;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
